fact_accel_mm: RTL and testbench
================================

Name: fact_accel_mm

Overview:
Memory-mapped iterative factorial accelerator; the parametrised successor of the current fixed-width factorial top. Host writes n and a go bit over a 2-bit address bus and polls status or waits for irq. Result width and input width are parameters. The block adds overflow detection, status readback and an interrupt.

Parameters:
N_W, 5, width of operand n and of write-data bus WD (must be >= 3)
DATA_W, 32, width of result register and read-data bus RD

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
WD  in  N_W  write data
WE  in  1  write enable, sampled on clk rising edge
A  in  2  register address
RD  out  DATA_W  read data, combinational from A
irq  out  1  interrupt, done & irq_en

Behaviour:
- Register map:
  - A=00 N: write n (RW; reads zero-extended).
  - A=01 CTRL: WD[0] go (write-1 pulse, reads 0), WD[1] irq_en (RW), WD[2] clr (write-1 pulse, clears done/err).
  - A=10 STATUS: RO; RD[0] busy, RD[1] done, RD[2] err, rest 0.
  - A=11 RESULT: RO; last completed result.
- Writes to RO addresses are ignored.
- Reset (rst=0, async): n=0, irq_en=0, product=0, cnt=0, result=0, done=0, err=0, state=IDLE. Consequently RD reflects zeroed registers and irq=0.
- States IDLE, MUL, DONE; busy=1 only in MUL.
- Go accepted only in IDLE or DONE. On the accepting edge (E0): state<=MUL, product<=1, cnt<=n, done<=0, err<=0.
- Each edge in MUL:
  - If cnt<=1: result<=product, done<=1, state<=DONE.
  - Else if product*cnt needs more than DATA_W bits: result<=all-ones, err<=1, done<=1, state<=DONE.
  - Else: product<=product*cnt, cnt<=cnt-1.
- Latency: done visible after max(n,1) edges following E0 if no overflow; on overflow, earlier. n=0 and n=1 both give 1.
- Multiply is 2*DATA_W wide, 1 cycle. Overflow = any upper DATA_W bit set.
- Writes while in MUL:
  - N write: ignored (n unchanged).
  - go: ignored.
  - irq_en: updated.
  - clr: ignored.
- DONE state:
  - result, done and err hold until clr or the next go.
  - clr returns to IDLE. result is kept.
  - go in DONE restarts directly.
- Simultaneous events:
  - go and clr in the same write: go wins.
  - go with n written the same cycle: impossible, since A differs between the two writes.
- RESULT read during MUL returns the previous completed value.
- rst deassertion mid-computation: block is in IDLE with everything cleared; no partial result is exposed.

Decomposition:
- Shared package fact_pkg:
  - Address constants ADDR_N, ADDR_CTRL, ADDR_STATUS, ADDR_RESULT.
  - CTRL bit indices GO_BIT, IRQEN_BIT, CLR_BIT.
  - STATUS bit indices.
  - State enum encodings S_IDLE, S_MUL, S_DONE.
- One sub-module fact_mul_step: combinational DATA_W x N_W multiply with an overflow flag.
- Top holds the register file, the FSM and the read mux.

Test Plan:
- Reset, then write N=4, go=1 -> busy=1 for 4 cycles, then STATUS=3'b010 and RESULT=24 (0x18). irq stays 0.
- N=12, irq_en=1, go -> RESULT=479001600 (0x1C8CFC00), err=0, irq=1. clr -> irq=0, STATUS=0, RESULT still 0x1C8CFC00.
- N=13 (DATA_W=32) -> err=1, done=1, RESULT=0xFFFFFFFF. N=0 and N=1 -> RESULT=1 after 1 cycle.
- During MUL of N=5: write N=3 and go again -> n reads 5, RESULT=120, and exactly one completion occurs.
- Assert rst low asynchronously mid-MUL (N=10) -> RD=0 on all addresses and irq=0 immediately. After release, go with N=3 -> RESULT=6.
- Write go and clr together in DONE -> new computation starts, busy=1. Write to STATUS -> no change.

Source files
------------

// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
//   Shared definitions for the memory-mapped factorial accelerator:
//   register addresses, CTRL/STATUS bit positions and the FSM state encoding.
//   No ports; imported by fact_mul_step and fact_accel_mm.
// -----------------------------------------------------------------------------
package fact_pkg;

   // Register map (2-bit address bus)
   localparam logic [1:0] ADDR_N      = 2'b00;
   localparam logic [1:0] ADDR_CTRL   = 2'b01;
   localparam logic [1:0] ADDR_STATUS = 2'b10;
   localparam logic [1:0] ADDR_RESULT = 2'b11;

   // CTRL bits: go and clr are write-1 pulses, irq_en is a stored bit
   localparam int GO_BIT    = 0;
   localparam int IRQEN_BIT = 1;
   localparam int CLR_BIT   = 2;

   // STATUS bits
   localparam int BUSY_BIT = 0;
   localparam int DONE_BIT = 1;
   localparam int ERR_BIT  = 2;

   // Controller states; busy is asserted only in S_MUL
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage : fact_pkg

// File: rtl/fact_mul_step.sv
// -----------------------------------------------------------------------------
// fact_mul_step
//   One combinational step of the factorial loop: multiplies the running
//   product by the current down-counter and flags when the exact result does
//   not fit in DATA_W bits.
//
//   Ports
//     product   in  DATA_W  running product
//     cnt       in  N_W     current multiplier (down-counter value)
//     prod_next out DATA_W  low DATA_W bits of product*cnt
//     ovf       out 1       any of the upper DATA_W bits of product*cnt set
// -----------------------------------------------------------------------------
module fact_mul_step
   import fact_pkg::*;
#(
   parameter int N_W    = 5,
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] product,
   input  logic [N_W-1:0]    cnt,
   output logic [DATA_W-1:0] prod_next,
   output logic              ovf
);

   // Full-width product so that overflow detection is exact.
   logic [2*DATA_W-1:0] full;

   assign full      = (2*DATA_W)'(product) * (2*DATA_W)'(cnt);
   assign prod_next = full[DATA_W-1:0];
   assign ovf       = |full[2*DATA_W-1:DATA_W];

endmodule : fact_mul_step

// File: rtl/fact_accel_mm.sv
// -----------------------------------------------------------------------------
// fact_accel_mm
//   Memory-mapped iterative factorial accelerator. The host writes n, then a
//   go pulse in CTRL, and either polls STATUS or waits for irq. One multiply
//   step is performed per clock; if an intermediate product would not fit in
//   DATA_W bits the result saturates to all-ones and err is raised.
//
//   Ports
//     clk  in   1       system clock, rising edge
//     rst  in   1       asynchronous active-low reset
//     WD   in   N_W     write data
//     WE   in   1       write enable, sampled on rising clk
//     A    in   2       register address (N / CTRL / STATUS / RESULT)
//     RD   out  DATA_W  read data, combinational from A
//     irq  out  1       done & irq_en
//
//   Handshake: the bus has no ready; a write with WE=1 is taken on the rising
//   edge it is presented at. Writes that are not meaningful in the current
//   state (N, go or clr while computing, anything to STATUS/RESULT) are
//   silently dropped, so the host never has to wait before writing.
// -----------------------------------------------------------------------------
module fact_accel_mm
   import fact_pkg::*;
#(
   parameter int N_W    = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_W-1:0]    WD,
   input  logic              WE,
   input  logic [1:0]        A,
   output logic [DATA_W-1:0] RD,
   output logic              irq
);

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   state_t              state_q;
   state_t              state_d;
   logic [N_W-1:0]      n_q;
   logic                irq_en_q;
   logic [DATA_W-1:0]   product_q;
   logic [N_W-1:0]      cnt_q;
   logic [DATA_W-1:0]   result_q;
   logic                done_q;
   logic                err_q;

   // ---------------------------------------------------------------------
   // Decoded bus writes
   // ---------------------------------------------------------------------
   logic wr_n;
   logic wr_ctrl;
   logic go_wr;
   logic clr_wr;
   logic go_acc;
   logic clr_acc;
   logic in_mul;
   logic last_step;

   assign wr_n    = WE && (A == ADDR_N);
   assign wr_ctrl = WE && (A == ADDR_CTRL);
   assign go_wr   = wr_ctrl && WD[GO_BIT];
   assign clr_wr  = wr_ctrl && WD[CLR_BIT];

   // Go and clr are only honoured outside the computation; go wins over clr.
   assign go_acc  = go_wr && (state_q != S_MUL);
   assign clr_acc = clr_wr && !go_wr && (state_q != S_MUL);

   // ---------------------------------------------------------------------
   // Multiply step
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] prod_next;
   logic              mul_ovf;

   fact_mul_step #(
      .N_W    (N_W),
      .DATA_W (DATA_W)
   ) u_mul_step (
      .product   (product_q),
      .cnt       (cnt_q),
      .prod_next (prod_next),
      .ovf       (mul_ovf)
   );

   // n=0 and n=1 terminate on the first step with product=1.
   assign last_step = (cnt_q <= N_W'(1));

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (go_acc) begin
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            if (last_step || mul_ovf) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (go_acc) begin
               state_d = S_MUL;
            end else if (clr_acc) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      in_mul = 1'b0;
      case (state_q)
         S_MUL:   in_mul = 1'b1;
         default: in_mul = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Host-visible configuration registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_q      <= '0;
         irq_en_q <= 1'b0;
      end else begin
         // n is frozen while a computation is running.
         if (wr_n && !in_mul) begin
            n_q <= WD;
         end
         // irq_en may be changed at any time.
         if (wr_ctrl) begin
            irq_en_q <= WD[IRQEN_BIT];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Datapath: product, counter, result and completion flags
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         product_q <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (go_acc) begin
            product_q <= DATA_W'(1);
            cnt_q     <= n_q;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
         end else if (clr_acc) begin
            // result is deliberately kept across clr.
            done_q <= 1'b0;
            err_q  <= 1'b0;
         end else if (in_mul) begin
            if (last_step) begin
               result_q <= product_q;
               done_q   <= 1'b1;
            end else if (mul_ovf) begin
               result_q <= '1;
               err_q    <= 1'b1;
               done_q   <= 1'b1;
            end else begin
               product_q <= prod_next;
               cnt_q     <= cnt_q - N_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read mux and interrupt
   // ---------------------------------------------------------------------
   always_comb begin
      RD = '0;
      case (A)
         ADDR_N: begin
            RD = DATA_W'(n_q);
         end
         ADDR_CTRL: begin
            // go and clr are pulses and always read back as 0.
            RD[IRQEN_BIT] = irq_en_q;
         end
         ADDR_STATUS: begin
            RD[BUSY_BIT] = in_mul;
            RD[DONE_BIT] = done_q;
            RD[ERR_BIT]  = err_q;
         end
         ADDR_RESULT: begin
            RD = result_q;
         end
         default: begin
            RD = '0;
         end
      endcase
   end

   assign irq = done_q & irq_en_q;

endmodule : fact_accel_mm

// File: tb/tb_fact_accel_mm.sv
// -----------------------------------------------------------------------------
// tb_fact_accel_mm
//   Directed bench for fact_accel_mm with a register-level reference model
//   and a per-cycle compare process, plus literal spot checks.
// -----------------------------------------------------------------------------
module tb_fact_accel_mm;

   localparam int N_W    = 5;
   localparam int DATA_W = 32;
   localparam logic [63:0] MAX_VAL = 64'hFFFF_FFFF;

   // ---------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------
   logic              clk = 1'b0;
   logic              rst;
   logic [N_W-1:0]    WD;
   logic              WE;
   logic [1:0]        A;
   logic [DATA_W-1:0] RD;
   logic              irq;

   always #5 clk = ~clk;

   fact_accel_mm #(
      .N_W    (N_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .WD  (WD),
      .WE  (WE),
      .A   (A),
      .RD  (RD),
      .irq (irq)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: factorial with saturation, and the number of clock
   // edges a computation takes (one per multiply, plus the final edge, or
   // up to and including the edge whose multiply would overflow).
   // ---------------------------------------------------------------------
   function automatic void model_fact(input int n, output logic [DATA_W-1:0] res,
                                      output logic err, output int lat);
      logic [63:0] f;
      logic [63:0] q;
      int          j;
      f   = 1;
      err = 1'b0;
      for (int i = 2; i <= n; i++) begin
         if (!err) begin
            if (f * i > MAX_VAL) err = 1'b1;
            else f = f * i;
         end
      end
      res = err ? '1 : f[DATA_W-1:0];
      if (!err) begin
         lat = (n < 2) ? 1 : n;
      end else begin
         q = 1;
         j = n;
         while (q * j <= MAX_VAL) begin
            q = q * j;
            j--;
         end
         lat = n - j + 1;
      end
   endfunction

   // Model register state
   logic [N_W-1:0]    m_n;
   logic              m_irq_en;
   logic              m_busy;
   logic              m_done;
   logic              m_err;
   logic [DATA_W-1:0] m_result;
   logic [DATA_W-1:0] m_pend_res;
   logic              m_pend_err;
   int                m_left;

   function automatic logic [DATA_W-1:0] exp_rd(input logic [1:0] a);
      case (a)
         2'b00:   return DATA_W'(m_n);
         2'b01:   return DATA_W'({m_irq_en, 1'b0});
         2'b10:   return DATA_W'({m_err, m_done, m_busy});
         default: return m_result;
      endcase
   endfunction

   initial begin : model_proc
      logic was_busy;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_n = '0; m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0;
            m_result = '0; m_left = 0;
         end else begin
            was_busy = m_busy;
            if (was_busy) begin
               m_left--;
               if (m_left == 0) begin
                  m_busy   = 0;
                  m_done   = 1;
                  m_err    = m_pend_err;
                  m_result = m_pend_res;
               end
            end
            if (WE && A == 2'b00 && !was_busy) m_n = WD;
            if (WE && A == 2'b01) begin
               m_irq_en = WD[1];
               if (!was_busy) begin
                  if (WD[0]) begin
                     model_fact(int'(m_n), m_pend_res, m_pend_err, m_left);
                     m_busy = 1; m_done = 0; m_err = 0;
                  end else if (WD[2]) begin
                     m_done = 0; m_err = 0;
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Scoreboard: compare RD (for the current address) and irq every cycle
   // ---------------------------------------------------------------------
   initial begin : compare_proc
      forever begin
         @(negedge clk);
         if (rst && chk_en) begin
            chk($sformatf("cyc_rd_a%0d", A), RD, exp_rd(A));
            chk("cyc_irq", DATA_W'(irq), DATA_W'(m_done & m_irq_en));
         end
      end
   end

   // ---------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [1:0] a, input int d);
      @(posedge clk);
      #2;
      A  = a;
      WD = N_W'(d);
      WE = 1'b1;
      @(posedge clk);
      #2;
      WE = 1'b0;
      A  = 2'b10;
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [DATA_W-1:0] exp,
                         input string name);
      A = a;
      #1;
      chk(name, RD, exp);
      A = 2'b10;
   endtask

   // ---------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------
   initial begin : main
      logic [DATA_W-1:0] r;
      logic              e;
      int                l;
      int                rises;
      logic              prev_done;

      rst = 1'b0; WE = 1'b0; A = 2'b00; WD = '0;

      // Pin the model with hand-computed values
      model_fact(4, r, e, l);  chk("model_4_res", r, 32'd24);       chk("model_4_lat", DATA_W'(l), 32'd4);
      model_fact(12, r, e, l); chk("model_12_res", r, 32'h1C8CFC00); chk("model_12_err", DATA_W'(e), 32'd0);
      model_fact(13, r, e, l); chk("model_13_res", r, 32'hFFFFFFFF); chk("model_13_lat", DATA_W'(l), 32'd12);
      model_fact(0, r, e, l);  chk("model_0_res", r, 32'd1);         chk("model_0_lat", DATA_W'(l), 32'd1);

      // Reset state
      cyc(2);
      for (int a = 0; a < 4; a++) rd_chk(2'(a), '0, $sformatf("reset_rd_a%0d", a));
      chk("reset_irq", DATA_W'(irq), '0);
      rst = 1'b1;
      chk_en = 1'b1;
      cyc(1);

      // n=4: busy for 4 cycles, then done with 24
      wr(2'b00, 4);
      wr(2'b01, 1);
      rd_chk(2'b10, 32'd1, "n4_busy_0");
      for (int i = 1; i < 4; i++) begin
         cyc(1);
         rd_chk(2'b10, 32'd1, $sformatf("n4_busy_%0d", i));
      end
      cyc(1);
      rd_chk(2'b10, 32'd2, "n4_status");
      rd_chk(2'b11, 32'd24, "n4_result");
      chk("n4_irq", DATA_W'(irq), '0);

      // n=12 with irq, then clr
      wr(2'b00, 12);
      wr(2'b01, 3);
      cyc(14);
      rd_chk(2'b11, 32'h1C8CFC00, "n12_result");
      rd_chk(2'b10, 32'd2, "n12_status");
      chk("n12_irq", DATA_W'(irq), 32'd1);
      wr(2'b01, 6);
      chk("clr_irq", DATA_W'(irq), '0);
      rd_chk(2'b10, 32'd0, "clr_status");
      rd_chk(2'b11, 32'h1C8CFC00, "clr_result_kept");
      rd_chk(2'b01, 32'd2, "ctrl_readback");

      // n=13 overflows
      wr(2'b00, 13);
      wr(2'b01, 1);
      cyc(14);
      rd_chk(2'b10, 32'd6, "n13_status");
      rd_chk(2'b11, 32'hFFFFFFFF, "n13_result");

      // n=0 and n=1: one cycle, result 1 (go straight from DONE)
      for (int k = 0; k < 2; k++) begin
         wr(2'b00, k);
         wr(2'b01, 1);
         rd_chk(2'b10, 32'd1, $sformatf("n%0d_busy", k));
         cyc(1);
         rd_chk(2'b10, 32'd2, $sformatf("n%0d_status", k));
         rd_chk(2'b11, 32'd1, $sformatf("n%0d_result", k));
      end

      // n=5 with N write and go during MUL
      wr(2'b00, 5);
      wr(2'b01, 1);
      wr(2'b00, 3);
      wr(2'b01, 1);
      rd_chk(2'b11, 32'd1, "mul_result_prev");
      A = 2'b10;
      #1;
      prev_done = RD[1];
      rises = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (RD[1] && !prev_done) rises++;
         prev_done = RD[1];
      end
      chk("n5_completions", DATA_W'(rises), 32'd1);
      rd_chk(2'b00, 32'd5, "n5_n_kept");
      rd_chk(2'b11, 32'd120, "n5_result");

      // Async reset mid computation
      wr(2'b00, 10);
      wr(2'b01, 3);
      cyc(3);
      #2;
      rst = 1'b0;
      for (int a = 0; a < 4; a++) rd_chk(2'(a), '0, $sformatf("midrst_rd_a%0d", a));
      chk("midrst_irq", DATA_W'(irq), '0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      wr(2'b00, 3);
      wr(2'b01, 1);
      cyc(5);
      rd_chk(2'b11, 32'd6, "after_rst_result");

      // go + clr together in DONE: go wins
      wr(2'b01, 5);
      rd_chk(2'b10, 32'd1, "goclr_busy");
      cyc(5);
      rd_chk(2'b10, 32'd2, "goclr_done");

      // Writes to read-only registers are ignored
      wr(2'b10, 7);
      rd_chk(2'b10, 32'd2, "ro_status");
      wr(2'b11, 7);
      rd_chk(2'b11, 32'd6, "ro_result");
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fact_accel_mm
